// File: rtl/extremum_finder_seq.sv
// Sequential max/min finder: snapshots N_INPUTS words on start, scans one per clock,
// then reports the extremum value and its index with a one-cycle done pulse.
module extremum_finder_seq #(
  parameter int WIDTH    = 5,
  parameter int N_INPUTS = 4,
  parameter int SIGNED   = 0,
  localparam int IDX_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_signal,
  input  logic                      mode,
  input  logic [N_INPUTS*WIDTH-1:0] x_bus,
  output logic [WIDTH-1:0]          result,
  output logic [IDX_W-1:0]          result_idx,
  output logic                      busy,
  output logic                      done
);

  // One extra count bit keeps cnt from wrapping when N_INPUTS is a power of two.
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state, state_next;
  logic [N_INPUTS*WIDTH-1:0] snap;
  logic                      mode_r;
  logic [WIDTH-1:0]          best;
  logic [IDX_W-1:0]          best_idx;
  logic [CNT_W-1:0]          cnt;
  logic [WIDTH-1:0]          elem;
  logic                      gt, lt, better, last;

  always_comb begin
    elem = snap[WIDTH-1:0];
    for (int i = 0; i < N_INPUTS; i++) begin
      if (cnt == CNT_W'(i)) elem = snap[i*WIDTH +: WIDTH];
    end
    if (SIGNED != 0) begin
      gt = $signed(elem) > $signed(best);
      lt = $signed(elem) < $signed(best);
    end else begin
      gt = elem > best;
      lt = elem < best;
    end
    // Strict comparison only, so ties keep the lowest index already held in best.
    better = mode_r ? lt : gt;
    last   = (cnt == CNT_W'(N_INPUTS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start_signal) state_next = (N_INPUTS == 1) ? DONE : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      mode_r     <= 1'b0;
      best       <= '0;
      best_idx   <= '0;
      cnt        <= '0;
      result     <= '0;
      result_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_signal) begin
            snap     <= x_bus;
            mode_r   <= mode;
            best     <= x_bus[WIDTH-1:0];
            best_idx <= '0;
            cnt      <= CNT_W'(1);
            if (N_INPUTS == 1) begin
              result     <= x_bus[WIDTH-1:0];
              result_idx <= '0;
            end
          end
        end
        SCAN: begin
          if (better) begin
            best     <= elem;
            best_idx <= cnt[IDX_W-1:0];
          end
          cnt <= cnt + CNT_W'(1);
          // The final element is folded straight into the published result.
          if (last) begin
            result     <= better ? elem : best;
            result_idx <= better ? cnt[IDX_W-1:0] : best_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_extremum_finder_seq.sv
// Bench for extremum_finder_seq: unsigned N=4 instance checked every cycle against a
// transaction model, plus directed checks on signed and single-input instances.
module tb_extremum_finder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [19:0] x0 = '0;
  logic        mode0 = 1'b0, start0 = 1'b0;
  logic [4:0]  result0;
  logic [1:0]  idx0;
  logic        busy0, done0;

  logic [19:0] x1 = '0;
  logic        mode1 = 1'b0, start1 = 1'b0;
  logic [4:0]  result1;
  logic [1:0]  idx1;
  logic        busy1, done1;

  logic [4:0]  x2 = '0;
  logic        mode2 = 1'b0, start2 = 1'b0;
  logic [4:0]  result2;
  logic [0:0]  idx2;
  logic        busy2, done2;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  extremum_finder_seq #(.WIDTH(5), .N_INPUTS(4), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start_signal(start0), .mode(mode0), .x_bus(x0),
    .result(result0), .result_idx(idx0), .busy(busy0), .done(done0));

  extremum_finder_seq #(.WIDTH(5), .N_INPUTS(4), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start_signal(start1), .mode(mode1), .x_bus(x1),
    .result(result1), .result_idx(idx1), .busy(busy1), .done(done1));

  extremum_finder_seq #(.WIDTH(5), .N_INPUTS(1), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .start_signal(start2), .mode(mode2), .x_bus(x2),
    .result(result2), .result_idx(idx2), .busy(busy2), .done(done2));

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [4:0] a, b, c, d;
    a = e0[4:0]; b = e1[4:0]; c = e2[4:0]; d = e3[4:0];
    return {d, c, b, a};
  endfunction

  // Reference: linear search, replacing only on a strictly better element.
  function automatic logic [6:0] extOf(input logic [19:0] bus, input logic m);
    logic [4:0] v, e;
    logic [1:0] ix;
    v  = bus[4:0];
    ix = 2'd0;
    for (int i = 1; i < 4; i++) begin
      e = bus[i*5 +: 5];
      if ((!m && e > v) || (m && e < v)) begin
        v  = e;
        ix = i[1:0];
      end
    end
    return {ix, v};
  endfunction

  // Transaction model for u0: m_left counts the busy cycles left in the current scan.
  int         m_left = 0;
  logic [6:0] m_pend = '0;
  logic [4:0] m_result = '0;
  logic [1:0] m_idx = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left   <= 0;
      m_result <= '0;
      m_idx    <= '0;
    end else if (m_left == 0) begin
      if (start0) begin
        m_pend <= extOf(x0, mode0);
        m_left <= 4;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) {m_idx, m_result} <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("cyc_busy", int'(busy0), int'(m_left > 0));
      checkOutput("cyc_done", int'(done0), int'(m_left == 1));
      checkOutput("cyc_result", int'(result0), int'(m_result));
      checkOutput("cyc_idx", int'(idx0), int'(m_idx));
    end
  end

  function automatic logic getDone(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Raises start for exactly one edge; returns at the negedge after that edge.
  task automatic applyStimulus(input int which, input logic [19:0] bus, input logic m);
    @(negedge clk);
    case (which)
      0:       begin x0 = bus; mode0 = m; start0 = 1'b1; end
      1:       begin x1 = bus; mode1 = m; start1 = 1'b1; end
      default: begin x2 = bus[4:0]; mode2 = m; start2 = 1'b1; end
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic waitDone(input int which, output int n);
    n = 0;
    while (!getDone(which) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!getDone(which)) checkOutput("done_timeout", n, -1);
  endtask

  initial begin
    int n, cnt_done;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_result", int'(result0), 0);
    checkOutput("rst_idx", int'(idx0), 0);
    checkOutput("rst_busy", int'(busy0), 0);
    checkOutput("rst_done", int'(done0), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    applyStimulus(0, pack4(3, 17, 9, 12), 1'b0);
    waitDone(0, n);
    checkOutput("max_lat", n, 3);
    checkOutput("max_val", int'(result0), 17);
    checkOutput("max_idx", int'(idx0), 1);

    applyStimulus(0, pack4(3, 17, 9, 12), 1'b1);
    waitDone(0, n);
    checkOutput("min_lat", n, 3);
    checkOutput("min_val", int'(result0), 3);
    checkOutput("min_idx", int'(idx0), 0);
    @(negedge clk);
    checkOutput("min_idle_busy", int'(busy0), 0);

    applyStimulus(0, pack4(9, 31, 31, 2), 1'b0);
    waitDone(0, n);
    checkOutput("tie_max_val", int'(result0), 31);
    checkOutput("tie_max_idx", int'(idx0), 1);

    applyStimulus(0, pack4(6, 2, 2, 2), 1'b1);
    waitDone(0, n);
    checkOutput("tie_min_val", int'(result0), 2);
    checkOutput("tie_min_idx", int'(idx0), 1);

    // Inputs and a second start change mid-scan; the captured snapshot must win.
    applyStimulus(0, pack4(1, 2, 3, 4), 1'b0);
    x0 = pack4(30, 30, 30, 30);
    mode0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitDone(0, n);
    checkOutput("ign_val", int'(result0), 4);
    checkOutput("ign_idx", int'(idx0), 3);
    cnt_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0) cnt_done++;
    end
    checkOutput("ign_extra_done", cnt_done, 0);

    // Reset during the second SCAN cycle aborts the scan.
    applyStimulus(0, pack4(3, 17, 9, 12), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_result", int'(result0), 0);
    checkOutput("abort_idx", int'(idx0), 0);
    checkOutput("abort_busy", int'(busy0), 0);
    cnt_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0) cnt_done++;
    end
    checkOutput("abort_no_done", cnt_done, 0);
    applyStimulus(0, pack4(3, 17, 9, 12), 1'b0);
    waitDone(0, n);
    checkOutput("rerun_lat", n, 3);
    checkOutput("rerun_val", int'(result0), 17);
    checkOutput("rerun_idx", int'(idx0), 1);

    applyStimulus(1, pack4(5'h1F, 4, 5'h10, 0), 1'b0);
    waitDone(1, n);
    checkOutput("s_max_lat", n, 3);
    checkOutput("s_max_val", int'(result1), 4);
    checkOutput("s_max_idx", int'(idx1), 1);
    applyStimulus(1, pack4(5'h1F, 4, 5'h10, 0), 1'b1);
    waitDone(1, n);
    checkOutput("s_min_val", int'(result1), 16);
    checkOutput("s_min_idx", int'(idx1), 2);

    applyStimulus(2, 20'd7, 1'b0);
    waitDone(2, n);
    checkOutput("n1_lat", n, 0);
    checkOutput("n1_val", int'(result2), 7);
    checkOutput("n1_idx", int'(idx2), 0);
    checkOutput("n1_busy", int'(busy2), 1);
    @(negedge clk);
    checkOutput("n1_idle", int'(busy2), 0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
